// File: rtl/cc1200_spi_master.sv
// CC1200 SPI master: one header byte plus 0..255 data bytes per command, mode 0, MSB first.
// Define CC1200_EXT_ADDR_EN to add the extended-address byte after the header.
module cc1200_spi_master #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned RDY_TIMEOUT = 1023
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic       burst,
  input  logic [5:0] addr,
  input  logic       ext_en,
  input  logic [7:0] ext_addr,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] status,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       CS_n
);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_WAIT_RDY, S_HDR, S_EXT, S_DATA, S_HOLD, S_DONE, S_ABORT
  } state_t;

  state_t           state;
  logic             miso_meta, miso_sync;
  logic             rw_q, burst_q;
  logic [5:0]       addr_q;
  logic [7:0]       len_q;
  logic [6:0]       sh_q;
  logic [6:0]       rx_sh_q;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt;
  logic             stall_q;

  logic             ext_go_c;
  logic [5:0]       hdr_addr_c;
  logic [7:0]       ext_byte_c;

`ifdef CC1200_EXT_ADDR_EN
  localparam logic [5:0] EXT_ESCAPE = 6'h2F;
  logic       ext_en_q;
  logic [7:0] ext_addr_q;
  assign ext_go_c   = ext_en_q;
  assign hdr_addr_c = ext_en_q ? EXT_ESCAPE : addr_q;
  assign ext_byte_c = ext_addr_q;
`else
  logic ext_unused_c;
  assign ext_unused_c = ^{ext_en, ext_addr};
  assign ext_go_c     = 1'b0;
  assign hdr_addr_c   = addr_q;
  assign ext_byte_c   = 8'h00;
`endif

  logic       shifting_c, bit_end_c, byte_end_c, more_data_c, begin_byte_c, can_load_c;
  logic [7:0] rx_byte_c;

  // Bit/byte boundary decode and "start another data byte" decision
  always_comb begin
    shifting_c  = (state == S_HDR || state == S_EXT || state == S_DATA) && !stall_q;
    bit_end_c   = shifting_c && SCLK && (div_cnt == DIV_W'(CLK_DIV - 1));
    byte_end_c  = bit_end_c && (bit_cnt == 3'd7);
    rx_byte_c   = {rx_sh_q, miso_sync};
    more_data_c = 1'b0;
    case (state)
      S_HDR:   more_data_c = !ext_go_c && (len_q != 8'd0);
      S_EXT:   more_data_c = (len_q != 8'd0);
      S_DATA:  more_data_c = (len_q != 8'd1);
      default: more_data_c = 1'b0;
    endcase
    begin_byte_c = (byte_end_c && more_data_c) || (state == S_DATA && stall_q);
    can_load_c   = rw_q || tx_valid;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
      rw_q      <= 1'b0;
      burst_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      sh_q      <= '0;
      rx_sh_q   <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      cnt       <= '0;
      stall_q   <= 1'b0;
`ifdef CC1200_EXT_ADDR_EN
      ext_en_q   <= 1'b0;
      ext_addr_q <= '0;
`endif
      tx_ready  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      status    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      CS_n      <= 1'b1;
    end else begin
      miso_meta <= MISO;
      miso_sync <= miso_meta;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;

      // SCLK half-period timing; sample at the end of the high phase, shift on the fall
      if (shifting_c) begin
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          SCLK    <= !SCLK;
          if (SCLK) begin
            rx_sh_q <= rx_byte_c[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            MOSI    <= sh_q[6];
            sh_q    <= {sh_q[5:0], 1'b0};
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            rw_q    <= rw;
            burst_q <= burst;
            addr_q  <= addr;
            len_q   <= len;
`ifdef CC1200_EXT_ADDR_EN
            ext_en_q   <= ext_en;
            ext_addr_q <= ext_addr;
`endif
            stall_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            CS_n    <= 1'b0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            cnt   <= '0;
            state <= S_WAIT_RDY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_RDY: begin
          if (!miso_sync) begin
            MOSI    <= rw_q;
            sh_q    <= {burst_q, hdr_addr_c};
            div_cnt <= '0;
            bit_cnt <= '0;
            SCLK    <= 1'b0;
            state   <= S_HDR;
          end else if (cnt == CNT_W'(RDY_TIMEOUT - 1)) begin
            CS_n  <= 1'b1;
            state <= S_ABORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HDR: begin
          if (byte_end_c) begin
            status <= rx_byte_c;
            if (ext_go_c) begin
              MOSI  <= ext_byte_c[7];
              sh_q  <= ext_byte_c[6:0];
              state <= S_EXT;
            end else if (!more_data_c) begin
              MOSI  <= 1'b0;
              cnt   <= '0;
              state <= S_HOLD;
            end
          end
        end
        S_EXT: begin
          if (byte_end_c && !more_data_c) begin
            MOSI  <= 1'b0;
            cnt   <= '0;
            state <= S_HOLD;
          end
        end
        S_DATA: begin
          if (byte_end_c) begin
            if (rw_q) begin
              rx_data  <= rx_byte_c;
              rx_valid <= 1'b1;
            end
            len_q <= len_q - 8'd1;
            if (!more_data_c) begin
              MOSI  <= 1'b0;
              cnt   <= '0;
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            CS_n  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ABORT: begin
          timeout <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Data byte start: reads shift zeros, writes need tx_valid or stall with SCLK low
      if (begin_byte_c) begin
        state <= S_DATA;
        if (can_load_c) begin
          stall_q  <= 1'b0;
          MOSI     <= rw_q ? 1'b0 : tx_data[7];
          sh_q     <= rw_q ? 7'd0 : tx_data[6:0];
          tx_ready <= !rw_q;
        end else begin
          stall_q <= 1'b1;
          MOSI    <= 1'b0;
        end
      end
    end
  end
endmodule
